// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_ctrl serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
        if (len == 0)
            return 1;
        else if (len > max)
            return max;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Detection datapath: history shift register, saturating bits_seen, masked compare.
// match_hit is the same-cycle compare result; match_pulse is its registered strobe.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W_MAX = 8,
    parameter int unsigned LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic [PAT_W_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]     len,
    output logic                 match_hit,
    output logic                 match_pulse
);

    localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(PAT_W_MAX);

    logic [PAT_W_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]     seen_q, seen_d;
    logic                 match_q, match_d;
    logic [PAT_W_MAX-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < PAT_W_MAX; k++)
            mask[k] = (k < 32'(len));
    end

    always_comb begin
        hist_d    = hist_q;
        seen_d    = seen_q;
        match_hit = 1'b0;
        if (clear) begin
            hist_d = '0;
            seen_d = '0;
        end else if (bit_valid) begin
            hist_d = (hist_q << 1) | PAT_W_MAX'(bit_in);
            if (seen_q != SEEN_MAX)
                seen_d = seen_q + 1'b1;
            // Compare against the history including the bit arriving this cycle.
            match_hit = (seen_d >= len) && (((hist_d ^ pattern) & mask) == '0);
        end
        match_d = match_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            match_q <= match_d;
        end
    end

    assign match_pulse = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time controller: word handshake, MSB-first serializer, match counter and sticky irq.
// Optional last_pos output and bit index counter enabled by SEQ_DET_CTRL_POS_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned PAT_W_MAX = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PAT_W_MAX-1:0] cfg_pattern,
    input  logic [3:0]           cfg_len,
    input  logic [CNT_W-1:0]     cfg_thresh,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 irq,
    input  logic                 irq_clr
`ifdef SEQ_DET_CTRL_POS_EN
    ,
    output logic [CNT_W-1:0]     last_pos
`endif
);

    localparam int unsigned LEN_W = $clog2(PAT_W_MAX + 1);
    localparam int unsigned BC_W  = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [WORD_W-1:0]    shreg_q, shreg_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PAT_W_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     thresh_q, thresh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 irq_q, irq_d;
`ifdef SEQ_DET_CTRL_POS_EN
    logic [CNT_W-1:0]     gidx_q, gidx_d;
    logic [CNT_W-1:0]     last_pos_q, last_pos_d;
`endif

    logic core_clear;
    logic bit_valid;
    logic match_hit;
    logic stop_now;
    logic accept;

    assign bit_valid = (state_q == SHIFT);
    assign stop_now  = stop_pend_q | stop;
    assign accept    = (state_q == RUN) && in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        pat_d       = pat_q;
        len_d       = len_q;
        thresh_d    = thresh_q;
        cnt_d       = cnt_q;
        irq_d       = irq_q & ~irq_clr;
        core_clear  = 1'b0;
`ifdef SEQ_DET_CTRL_POS_EN
        gidx_d      = gidx_q;
        last_pos_d  = last_pos_q;
`endif

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d    = RUN;
                    pat_d      = cfg_pattern;
                    len_d      = LEN_W'(clamp_len(32'(cfg_len), PAT_W_MAX));
                    thresh_d   = cfg_thresh;
                    cnt_d      = '0;
                    core_clear = 1'b1;
`ifdef SEQ_DET_CTRL_POS_EN
                    gidx_d     = '0;
                    last_pos_d = '0;
`endif
                end
            end
            RUN: begin
                stop_pend_d = stop_now;
                // A completed handshake is honoured; a pending stop then waits for that word.
                if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                end else if (stop_now) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end
            end
            SHIFT: begin
                stop_pend_d = stop_now;
                shreg_d     = shreg_q << 1;
                bit_cnt_d   = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BC_LAST) begin
                    bit_cnt_d = '0;
                    if (stop_now) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (match_hit && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
            if (thresh_q != '0 && cnt_d == thresh_q)
                irq_d = 1'b1;
        end

`ifdef SEQ_DET_CTRL_POS_EN
        if (bit_valid) begin
            if (match_hit)
                last_pos_d = gidx_q;
            if (gidx_q != '1)
                gidx_d = gidx_q + 1'b1;
        end
`endif

        in_ready_d = (state_d == RUN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            thresh_q    <= '0;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
`ifdef SEQ_DET_CTRL_POS_EN
            gidx_q      <= '0;
            last_pos_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            stop_pend_q <= stop_pend_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            thresh_q    <= thresh_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
`ifdef SEQ_DET_CTRL_POS_EN
            gidx_q      <= gidx_d;
            last_pos_q  <= last_pos_d;
`endif
        end
    end

    seq_det_core #(
        .PAT_W_MAX (PAT_W_MAX),
        .LEN_W     (LEN_W)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .clear       (core_clear),
        .bit_valid   (bit_valid),
        .bit_in      (shreg_q[WORD_W-1]),
        .pattern     (pat_q),
        .len         (len_q),
        .match_hit   (match_hit),
        .match_pulse (match_pulse)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;
`ifdef SEQ_DET_CTRL_POS_EN
    assign last_pos  = last_pos_q;
`endif

endmodule
